// File: rtl/poci_master.sv
// POCI/APB-style bus initiator: one SETUP+ACCESS transfer per accepted request, response via valid/ready.
// Latency 3 cycles request-to-response with zero wait states; an ACCESS-phase wait-state timeout bounds hung peripherals.
module poci_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_req_valid,
  output logic              io_req_ready,
  input  logic [ADDR_W-1:0] io_req_addr,
  input  logic              io_req_write,
  input  logic [DATA_W-1:0] io_req_wdata,
  output logic              io_resp_valid,
  input  logic              io_resp_ready,
  output logic [DATA_W-1:0] io_resp_rdata,
  output logic              io_resp_err,
  output logic              io_resp_timeout,
  output logic [ADDR_W-1:0] io_bus_paddr,
  output logic              io_bus_pwrite,
  output logic              io_bus_psel,
  output logic              io_bus_penable,
  output logic [DATA_W-1:0] io_bus_pwdata,
  input  logic [DATA_W-1:0] io_bus_prdata,
  input  logic              io_bus_pready,
  input  logic              io_bus_pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam bit              TMO_EN   = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cnt             <= '0;
      io_req_ready    <= 1'b1;
      io_resp_valid   <= 1'b0;
      io_resp_rdata   <= '0;
      io_resp_err     <= 1'b0;
      io_resp_timeout <= 1'b0;
      io_bus_paddr    <= '0;
      io_bus_pwrite   <= 1'b0;
      io_bus_psel     <= 1'b0;
      io_bus_penable  <= 1'b0;
      io_bus_pwdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_req_valid) begin
            io_bus_paddr  <= io_req_addr;
            io_bus_pwrite <= io_req_write;
            io_bus_pwdata <= io_req_wdata;
            io_bus_psel   <= 1'b1;
            io_req_ready  <= 1'b0;
            state         <= SETUP;
          end
        end
        SETUP: begin
          io_bus_penable <= 1'b1;
          cnt            <= '0;
          state          <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so a completion on the last allowed cycle is not reported as a timeout
          if (io_bus_pready) begin
            io_resp_rdata   <= io_bus_pwrite ? '0 : io_bus_prdata;
            io_resp_err     <= io_bus_pslverr;
            io_resp_timeout <= 1'b0;
            io_bus_psel     <= 1'b0;
            io_bus_penable  <= 1'b0;
            io_resp_valid   <= 1'b1;
            state           <= RESP;
          end else if (TMO_EN && cnt == TMO_LAST) begin
            io_resp_rdata   <= '0;
            io_resp_err     <= 1'b1;
            io_resp_timeout <= 1'b1;
            io_bus_psel     <= 1'b0;
            io_bus_penable  <= 1'b0;
            io_resp_valid   <= 1'b1;
            state           <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (io_resp_ready) begin
            io_resp_valid <= 1'b0;
            io_req_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/poci_master.md
Name: poci_master

Overview:
- POCI/APB-style bus initiator: takes single transfer requests from a simple valid/ready command port and drives one bus transfer per request.
- Sequences each transfer as SETUP then ACCESS phase; waits on pready; returns prdata/pslverr on a valid/ready response port.
- Sits between a host-side controller (UART/debug bridge or soft CPU shim) and POCI peripherals such as the GPIO block.
- Provides a wait-state timeout so a hung peripheral cannot lock up the host.

Parameters:
- ADDR_W, 32, width of paddr and request address
- DATA_W, 32, width of pwdata/prdata and request/response data
- TIMEOUT, 256, max ACCESS-phase cycles without pready before abort; 0 disables the timeout
- CNT_W, 9, wait counter width; must hold TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous reset, active-low; asserted when 0
- io_req_valid  in  1  request present
- io_req_ready  out  1  request accepted this cycle when high with valid
- io_req_addr  in  ADDR_W  transfer address
- io_req_write  in  1  1=write, 0=read
- io_req_wdata  in  DATA_W  write data
- io_resp_valid  out  1  response present
- io_resp_ready  in  1  response consumed
- io_resp_rdata  out  DATA_W  read data; 0 for writes and aborts
- io_resp_err  out  1  pslverr seen or timeout
- io_resp_timeout  out  1  transfer aborted by timeout
- io_bus_paddr  out  ADDR_W
- io_bus_pwrite  out  1
- io_bus_psel  out  1
- io_bus_penable  out  1
- io_bus_pwdata  out  DATA_W
- io_bus_prdata  in  DATA_W
- io_bus_pready  in  1
- io_bus_pslverr  in  1

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0 except io_req_ready=1; wait counter 0.
- All bus outputs come directly from registers; no combinational path from bus inputs to bus outputs.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - io_req_ready=1.
  - On req_valid: latch addr/write/wdata into paddr/pwrite/pwdata; next state SETUP.
  - pwdata loads io_req_wdata on reads too; the value is don't-care but is registered.
- SETUP (exactly 1 cycle): psel=1, penable=0; next state ACCESS; wait counter cleared.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held stable.
  - pready=1: capture rdata = pwrite ? 0 : prdata; err = pslverr; timeout = 0; drop psel/penable; next state RESP.
  - pready=0 with TIMEOUT>0 and counter==TIMEOUT-1: abort. rdata=0, err=1, timeout=1; drop psel/penable; next state RESP.
  - Otherwise counter increments.
  - pready wins over timeout when both occur in the same cycle.
- RESP:
  - resp_valid=1; rdata/err/timeout held stable.
  - On resp_ready: next state IDLE; resp_valid=0 next cycle.
  - io_req_ready=0 in SETUP, ACCESS and RESP, so at most one outstanding transfer.
- Latency: request accepted at cycle N; SETUP at N+1; ACCESS at N+2; with zero wait states resp_valid=1 at N+3.
- Throughput: minimum 4 cycles per transfer when resp_ready is held high.
- paddr/pwrite/pwdata keep their last values in IDLE/RESP; they are 0 only after reset.
- Reset mid-transfer: psel/penable drop immediately (async); the response is lost; FSM returns to IDLE.

Test Plan:
- Read, zero wait: req addr=0x0, write=0; peripheral prdata=0x0000000A, pready=1 -> psel only at N+1, psel+penable at N+2; resp_valid at N+3 with rdata=0xA, err=0, timeout=0.
- Write with 3 wait states: addr=0x4, wdata=0x5; pready low for 3 ACCESS cycles -> paddr=0x4 and pwdata=0x5 stable throughout; resp_valid at N+6 with rdata=0, err=0.
- Slave error: pslverr=1 with pready=1 on a read -> resp err=1, timeout=0, rdata=prdata.
- Timeout: TIMEOUT=8, pready held 0 -> exactly 8 ACCESS cycles, then psel=0; resp err=1, timeout=1, rdata=0. Repeat with pready=1 on the 8th cycle -> normal completion, timeout=0.
- Response backpressure: resp_ready=0 for 5 cycles while req_valid stays high -> req_ready=0, resp fields stable, no new SETUP; the next transfer starts the cycle after the handshake.
- Reset mid-ACCESS: drive reset=0 asynchronously during ACCESS -> psel/penable/resp_valid go to 0 without waiting for a clock edge; req_ready=1 after release; a subsequent read completes normally.
